// File: rtl/wb_master_seq.sv
// wb_master_seq -- Wishbone classic single-transfer initiator.
//
// Takes one command at a time on a valid/ready interface, runs exactly one
// Wishbone classic cycle for it and returns the read data (or a timeout
// error) on a valid/ready response interface. Meant for on-chip sequencers
// and bring-up logic that poke harness registers without the management core.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_we/adr/dat/sel      command fields (write flag, byte address, data, byte select)
//   rsp_valid/rsp_ready     response handshake
//   rsp_dat, rsp_err        read data (0 for writes/errors), timeout flag
//   wbm_*                   Wishbone master port
//   txn_count               acked transactions, wraps
//   timeout_count           timed-out transactions, saturates at 255
module wb_master_seq #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [31:0]          cmd_adr,
  input  logic [31:0]          cmd_dat,
  input  logic [3:0]           cmd_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_dat,
  output logic                 rsp_err,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  input  logic                 wbm_ack_i,
  input  logic [31:0]          wbm_dat_i,
  output logic [CNT_WIDTH-1:0] txn_count,
  output logic [7:0]           timeout_count
);

  // Timer counts 0 .. TIMEOUT_CYCLES-1, one step per strobe cycle without ack.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  // NOTE: all state and outputs are registered here with non-blocking
  // assignments so every reader sees the pre-edge value; the reset branch
  // is sampled on the clock edge, which makes it synchronous.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      timer         <= '0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_dat       <= '0;
      rsp_err       <= 1'b0;
      wbm_cyc_o     <= 1'b0;
      wbm_stb_o     <= 1'b0;
      wbm_we_o      <= 1'b0;
      wbm_sel_o     <= '0;
      wbm_adr_o     <= '0;
      wbm_dat_o     <= '0;
      txn_count     <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Acks arriving here are stale and deliberately ignored.
          if (cmd_valid && cmd_ready) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            cmd_ready <= 1'b0;
            timer     <= '0;
            state     <= BUS;
          end
        end

        BUS: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            txn_count <= txn_count + 1'b1;
            state     <= RESP;
          end else if (timer == TIMER_LAST) begin
            // This edge ends the TIMEOUT_CYCLES-th strobe cycle.
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= 32'h0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            if (timeout_count != 8'hFF) begin
              timeout_count <= timeout_count + 1'b1;
            end
            state     <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_seq.sv
// tb_wb_master_seq -- self-checking bench for wb_master_seq.
//
// A small registered-ack slave models the harness: four words at
// 0x30000000..0x3000000C (word 0 is active_project), everything else is
// unmapped and never acks. A table of single transfers is applied in a loop,
// followed by hand-written sequences for backpressure, reset during BUS,
// stray acks and back-to-back throughput.
module tb_wb_master_seq;

  localparam int TO  = 8;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [31:0]   cmd_adr;
  logic [31:0]   cmd_dat;
  logic [3:0]    cmd_sel;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_dat;
  logic          rsp_err;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [3:0]    wbm_sel_o;
  logic [31:0]   wbm_adr_o;
  logic [31:0]   wbm_dat_o;
  logic          wbm_ack_i;
  logic [31:0]   wbm_dat_i;
  logic [CW-1:0] txn_count;
  logic [7:0]    timeout_count;

  wb_master_seq #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_we        (cmd_we),
    .cmd_adr       (cmd_adr),
    .cmd_dat       (cmd_dat),
    .cmd_sel       (cmd_sel),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_dat       (rsp_dat),
    .rsp_err       (rsp_err),
    .wbm_cyc_o     (wbm_cyc_o),
    .wbm_stb_o     (wbm_stb_o),
    .wbm_we_o      (wbm_we_o),
    .wbm_sel_o     (wbm_sel_o),
    .wbm_adr_o     (wbm_adr_o),
    .wbm_dat_o     (wbm_dat_o),
    .wbm_ack_i     (wbm_ack_i),
    .wbm_dat_i     (wbm_dat_i),
    .txn_count     (txn_count),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  // ---------------- harness slave model ----------------
  logic [31:0] mem [4];
  logic        slave_ack;
  logic        stray_ack;
  logic [31:0] slave_dat;
  logic        mapped;

  assign mapped    = (wbm_adr_o[31:4] == 28'h3000000);
  assign wbm_ack_i = slave_ack | stray_ack;
  assign wbm_dat_i = slave_dat;

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    slave_ack = 1'b0;
    slave_dat = 32'h0;
  end

  always @(posedge clk) begin
    slave_ack <= wbm_cyc_o & wbm_stb_o & ~slave_ack & mapped;
    if (wbm_cyc_o && wbm_stb_o && !slave_ack && mapped) begin
      if (wbm_we_o) begin
        for (int b = 0; b < 4; b++)
          if (wbm_sel_o[b]) mem[wbm_adr_o[3:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
        slave_dat <= 32'hFFFF_FFFF;  // junk on write acks; must not reach rsp_dat
      end else begin
        slave_dat <= mem[wbm_adr_o[3:2]];
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_stb;
  } vec_t;

  vec_t vecs[8];
  int   exp_txn;
  int   exp_to;

  // Issue one command from IDLE and check its whole life through to the pop.
  task automatic do_txn(input vec_t v, input int idx);
    int   n;
    int   stb_cycles;
    logic bad_hold;
    cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
    cmd_valid = 1'b1;
    check($sformatf("v%0d cmd_ready_idle", idx), {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check($sformatf("v%0d stb_after_accept", idx), {30'b0, wbm_cyc_o, wbm_stb_o}, 32'd3);
    n = 0; stb_cycles = 0; bad_hold = 1'b0;
    while (!rsp_valid && n < 50) begin
      if (wbm_stb_o) stb_cycles++;
      if (wbm_adr_o !== v.adr || wbm_dat_o !== v.dat || wbm_sel_o !== v.sel || wbm_we_o !== v.we)
        bad_hold = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (!v.exp_err) exp_txn++;
    else if (exp_to < 255) exp_to++;
    check($sformatf("v%0d rsp_valid", idx),   {31'b0, rsp_valid}, 32'd1);
    check($sformatf("v%0d stb_cycles", idx),  stb_cycles, v.exp_stb);
    check($sformatf("v%0d bus_hold", idx),    {31'b0, bad_hold}, 32'd0);
    check($sformatf("v%0d cyc_in_resp", idx), {31'b0, wbm_cyc_o}, 32'd0);
    check($sformatf("v%0d rsp_err", idx),     {31'b0, rsp_err}, {31'b0, v.exp_err});
    check($sformatf("v%0d rsp_dat", idx),     rsp_dat, v.exp_dat);
    check($sformatf("v%0d txn_count", idx),   {16'b0, txn_count}, exp_txn);
    check($sformatf("v%0d timeout_count", idx), {24'b0, timeout_count}, exp_to);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check($sformatf("v%0d rsp_popped", idx), {30'b0, rsp_valid, cmd_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        bad;
    int          n;
    int          rise_edge [3];
    int          n_rise;
    int          low_run;
    int          min_low;
    logic        prev_stb;

    vecs[0] = '{1'b1, 32'h3000_0000, 32'h0000_0002, 4'hF, 1'b0, 32'h0000_0000, 2};
    vecs[1] = '{1'b0, 32'h3000_0000, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0002, 2};
    vecs[2] = '{1'b1, 32'h3000_0300, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0000_0000, TO};
    vecs[3] = '{1'b1, 32'h3000_0004, 32'hA5A5_A5A5, 4'h5, 1'b0, 32'h0000_0000, 2};
    vecs[4] = '{1'b0, 32'h3000_0004, 32'h0000_0000, 4'hF, 1'b0, 32'h00A5_00A5, 2};
    vecs[5] = '{1'b0, 32'h3000_0310, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0000, TO};
    vecs[6] = '{1'b1, 32'h3000_0008, 32'h1122_3344, 4'hC, 1'b0, 32'h0000_0000, 2};
    vecs[7] = '{1'b0, 32'h3000_0008, 32'h0000_0000, 4'hF, 1'b0, 32'h1122_0000, 2};

    reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; stray_ack = 1'b0;
    cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0; cmd_sel = 4'h0;
    exp_txn = 0; exp_to = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst cyc_stb",   {30'b0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    check("rst rsp",       {30'b0, rsp_valid, rsp_err}, 32'd0);
    check("rst rsp_dat",   rsp_dat, 32'h0);
    check("rst wbm_adr",   wbm_adr_o, 32'h0);
    check("rst counters",  {8'b0, txn_count, timeout_count}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // ---- table of single transfers ----
    for (int i = 0; i < 8; i++) do_txn(vecs[i], i);
    check("active_project", mem[0], 32'h0000_0002);

    // ---- stray ack while idle ----
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    @(posedge clk); #1;
    check("stray idle state", {29'b0, rsp_valid, cmd_ready, wbm_cyc_o}, 32'd2);
    check("stray counters",   {8'b0, txn_count, timeout_count}, {8'b0, 16'd6, 8'd2});

    // ---- response backpressure with a pending command ----
    cmd_we = 1'b0; cmd_adr = 32'h3000_0000; cmd_sel = 4'hF; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("bp rsp_valid", {31'b0, rsp_valid}, 32'd1);
    cmd_we = 1'b1; cmd_adr = 32'h3000_000C; cmd_dat = 32'hCAFE_F00D; cmd_valid = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!rsp_valid || rsp_dat !== 32'h2 || rsp_err || cmd_ready || wbm_cyc_o) bad = 1'b1;
      @(posedge clk); #1;
    end
    check("bp held stable", {31'b0, bad}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp not yet accepted", {29'b0, rsp_valid, cmd_ready, wbm_cyc_o}, 32'd2);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bp accepted next", {30'b0, cmd_ready, wbm_stb_o}, 32'd1);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("bp second rsp", {30'b0, rsp_valid, rsp_err}, 32'd2);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp txn_count", {16'b0, txn_count}, 32'd8);
    check("bp write landed", mem[3], 32'hCAFE_F00D);

    // ---- reset on the second BUS cycle of a read ----
    cmd_we = 1'b0; cmd_adr = 32'h3000_0000; cmd_sel = 4'hF; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("mid rst cyc_stb",  {30'b0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    check("mid rst handshake", {30'b0, rsp_valid, cmd_ready}, 32'd1);
    check("mid rst counters", {8'b0, txn_count, timeout_count}, 32'h0);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid || wbm_cyc_o) bad = 1'b1;
      @(posedge clk); #1;
    end
    check("mid rst no rsp", {31'b0, bad}, 32'd0);

    // ---- three back-to-back reads, cmd_valid and rsp_ready held high ----
    for (int i = 0; i < 3; i++) rise_edge[i] = 0;
    n_rise = 0; low_run = 0; min_low = 1000; prev_stb = wbm_stb_o;
    cmd_we = 1'b0; cmd_adr = 32'h3000_0000; cmd_sel = 4'hF;
    rsp_ready = 1'b1; cmd_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (wbm_stb_o && !prev_stb) begin
        if (n_rise > 0 && low_run < min_low) min_low = low_run;
        if (n_rise < 3) rise_edge[n_rise] = k;
        n_rise++;
        if (n_rise == 3) cmd_valid = 1'b0;
      end
      if (!wbm_cyc_o) low_run++;
      else low_run = 0;
      prev_stb = wbm_stb_o;
    end
    rsp_ready = 1'b0;
    check("b2b accepts",    n_rise, 32'd3);
    check("b2b spacing 1",  rise_edge[1] - rise_edge[0], 32'd4);
    check("b2b spacing 2",  rise_edge[2] - rise_edge[1], 32'd4);
    check("b2b cyc gap",    {31'b0, (min_low >= 2)}, 32'd1);
    check("b2b txn_count",  {16'b0, txn_count}, 32'd3);
    check("b2b idle after", {30'b0, cmd_ready, wbm_cyc_o}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
